// File: rtl/spike_sampler.sv
// spike_sampler: walks an LFSR over neuron IDs and streams {value, id} samples
// taken from a per-round snapshot of spike_in over a valid/ready port.
module spike_sampler #(
  parameter int TEN_DATA_WIDTH    = 2,
  parameter int NUM_NEURON        = 1024,
  parameter int NEURON_ID_WIDTH   = 10,
  parameter int NUM_SAMPLES_WIDTH = 4,
  parameter logic [NEURON_ID_WIDTH-1:0] LFSR_SEED = 10'h32D,
  parameter logic [NEURON_ID_WIDTH-1:0] LFSR_TAPS = 10'h240
) (
  input  logic                                      clk,
  input  logic                                      reset_l,
  input  logic                                      en_network,
  input  logic [TEN_DATA_WIDTH*NUM_NEURON-1:0]      spike_in,
  input  logic [NUM_SAMPLES_WIDTH-1:0]              num_samples,
  input  logic                                      skip_zero,
  input  logic                                      spike_out_ready,
  output logic                                      spike_out_valid,
  output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_out,
  output logic                                      networkDone,
  output logic                                      busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int IDX_W = $clog2(NUM_NEURON);
  // Value of the attempt counter on the last rejection allowed in a row.
  localparam logic [NEURON_ID_WIDTH-1:0] ATT_LAST = ~NEURON_ID_WIDTH'(1);

  logic [1:0]                                state_q, state_d;
  logic [NEURON_ID_WIDTH-1:0]                lfsr_q, lfsr_d;
  logic [NEURON_ID_WIDTH-1:0]                att_q, att_d;
  logic [NUM_SAMPLES_WIDTH-1:0]              cnt_q, cnt_d;
  logic [NUM_SAMPLES_WIDTH-1:0]              num_q;
  logic                                      skip_q;
  logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] out_q, out_d;
  logic [TEN_DATA_WIDTH-1:0]                 snap_q [NUM_NEURON];

  logic                       load;
  logic                       fb;
  logic [NEURON_ID_WIDTH-1:0] cand;
  logic [IDX_W-1:0]           cand_idx;
  logic [TEN_DATA_WIDTH-1:0]  cand_val;
  logic                       in_range;
  logic                       accept;

  assign fb       = ^(lfsr_q & LFSR_TAPS);
  assign cand     = {lfsr_q[NEURON_ID_WIDTH-2:0], fb};
  assign cand_idx = cand[IDX_W-1:0];
  assign in_range = {1'b0, cand} < (NEURON_ID_WIDTH+1)'(NUM_NEURON);
  assign cand_val = snap_q[cand_idx];
  // The snapshot read is only trusted once the ID is known to be in range.
  assign accept   = in_range && (!skip_q || (cand_val != '0));

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    att_d   = att_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_network) begin
          if (num_samples != '0) begin
            load    = 1'b1;
            cnt_d   = '0;
            att_d   = '0;
            state_d = STEP;
          end else begin
            state_d = DONE;
          end
        end
      end
      STEP: begin
        lfsr_d = cand;
        if (accept) begin
          out_d   = {cand_val, cand};
          state_d = EMIT;
        end else begin
          att_d = att_q + NEURON_ID_WIDTH'(1);
          if (att_q == ATT_LAST) state_d = DONE;
        end
      end
      EMIT: begin
        if (spike_out_ready) begin
          cnt_d   = cnt_q + NUM_SAMPLES_WIDTH'(1);
          att_d   = '0;
          state_d = (cnt_d == num_q) ? DONE : STEP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      att_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      skip_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      att_q   <= att_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      if (load) begin
        num_q  <= num_samples;
        skip_q <= skip_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < NUM_NEURON; i++) snap_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_NEURON; i++)
        snap_q[i] <= spike_in[TEN_DATA_WIDTH*i +: TEN_DATA_WIDTH];
    end
  end

  assign spike_out_valid = (state_q == EMIT);
  assign networkDone     = (state_q == DONE);
  assign busy            = (state_q != IDLE);
  assign spike_out       = out_q;

endmodule

// File: tb/tb_spike_sampler.sv
// tb_spike_sampler: directed rounds checked against a round-planning reference
// model plus hand-computed literals for the key scenarios.
module tb_spike_sampler;
  localparam int NN = 1000;
  localparam int TW = 2;
  localparam int PH_IDLE = 0, PH_SEARCH = 1, PH_SHOW = 2, PH_FIN = 3;

  logic              clk = 1'b0;
  logic              reset_l = 1'b0;
  logic              en_network = 1'b0;
  logic [TW*NN-1:0]  spike_in = '0;
  logic [3:0]        num_samples = '0;
  logic              skip_zero = 1'b0;
  logic              spike_out_ready = 1'b1;
  logic              spike_out_valid;
  logic [11:0]       spike_out;
  logic              networkDone;
  logic              busy;

  int n_cmp = 0;
  int n_fail = 0;

  spike_sampler #(
    .TEN_DATA_WIDTH(TW), .NUM_NEURON(NN), .NEURON_ID_WIDTH(10),
    .NUM_SAMPLES_WIDTH(4), .LFSR_SEED(10'h32D), .LFSR_TAPS(10'h240)
  ) dut (
    .clk(clk), .reset_l(reset_l), .en_network(en_network), .spike_in(spike_in),
    .num_samples(num_samples), .skip_zero(skip_zero), .spike_out_ready(spike_out_ready),
    .spike_out_valid(spike_out_valid), .spike_out(spike_out),
    .networkDone(networkDone), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a round is planned in full when it starts (which candidates
  // are taken and how many search cycles each costs), then replayed per cycle.
  typedef struct { int steps; bit early; logic [11:0] word; } item_t;
  item_t plan[$];
  item_t cur = '{steps: 0, early: 1'b0, word: 12'h0};
  int    m_phase = PH_IDLE;
  int    m_left = 0;
  int    m_lfsr = 'h32D;

  function automatic int next_id(input int x);
    int fb;
    fb = $countones(x & 'h240) % 2;
    return ((x << 1) | fb) & 'h3FF;
  endfunction

  function automatic int val_of(input int id);
    return int'(spike_in[TW*id +: TW]);
  endfunction

  task automatic plan_round(input int n, input bit skip);
    plan.delete();
    for (int k = 0; k < n; k++) begin
      item_t it;
      it.early = 1'b1;
      it.steps = 1023;
      it.word  = '0;
      for (int r = 1; r <= 1023; r++) begin
        m_lfsr = next_id(m_lfsr);
        if (m_lfsr < NN && (!skip || val_of(m_lfsr) != 0)) begin
          it.early = 1'b0;
          it.steps = r;
          it.word  = {2'(val_of(m_lfsr)), 10'(m_lfsr)};
          break;
        end
      end
      plan.push_back(it);
      if (it.early) break;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_l);
    if (!reset_l) begin
      m_phase = PH_IDLE;
      m_lfsr  = 'h32D;
      plan.delete();
    end else begin
      case (m_phase)
        PH_IDLE: if (en_network) begin
          if (num_samples == 0) m_phase = PH_FIN;
          else begin
            plan_round(int'(num_samples), skip_zero);
            cur = plan.pop_front();
            m_left = cur.steps;
            m_phase = PH_SEARCH;
          end
        end
        PH_SEARCH: begin
          m_left--;
          if (m_left == 0) m_phase = cur.early ? PH_FIN : PH_SHOW;
        end
        PH_SHOW: if (spike_out_ready) begin
          if (plan.size() == 0) m_phase = PH_FIN;
          else begin
            cur = plan.pop_front();
            m_left = cur.steps;
            m_phase = PH_SEARCH;
          end
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    chk("valid", spike_out_valid, m_phase == PH_SHOW);
    chk("busy", busy, m_phase != PH_IDLE);
    chk("done", networkDone, m_phase == PH_FIN);
    if (m_phase == PH_SHOW) chk("word", spike_out, cur.word);
    if (spike_out_valid) chk("id_range", (spike_out[9:0] != 0) && (spike_out[9:0] < NN), 1);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_all(input int v);
    for (int i = 0; i < NN; i++) spike_in[TW*i +: TW] = 2'(v);
  endtask

  task automatic rand_spikes();
    for (int i = 0; i < NN; i++) spike_in[TW*i +: TW] = 2'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_l = 1'b0;
    en_network = 1'b0;
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  task automatic start_round(input int n, input bit skip);
    @(negedge clk);
    num_samples = 4'(n);
    skip_zero   = skip;
    en_network  = 1'b1;
  endtask

  // hold>0: ready low until that many valid cycles seen; hold<0: random ready.
  task automatic observe(input int hold, input bit scramble, input int budget,
                         output int lat_v, output int lat_d, output int nvalid,
                         output int hs, output logic [11:0] w0);
    lat_v = -1; lat_d = -1; nvalid = 0; hs = 0; w0 = '0;
    spike_out_ready = (hold == 0);
    for (int t = 1; t <= budget; t++) begin
      @(negedge clk);
      en_network = scramble && (t == 3);
      if (scramble && (t % 4 == 0)) begin
        rand_spikes();
        num_samples = 4'($urandom);
        skip_zero = 1'($urandom);
      end
      if (hold < 0) spike_out_ready = 1'($urandom_range(0, 1));
      if (spike_out_valid) begin
        if (nvalid == 0) begin
          lat_v = t;
          w0 = spike_out;
        end
        nvalid++;
        if (nvalid == hold) spike_out_ready = 1'b1;
        if (spike_out_ready) hs++;
      end
      if (networkDone) begin
        lat_d = t;
        break;
      end
    end
    en_network = 1'b0;
    spike_out_ready = 1'b1;
    chk("round_finished", lat_d > 0, 1);
  endtask

  int lv, ld, nv, hs;
  logic [11:0] w0;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", spike_out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", networkDone, 0);
    chk("rst_word", spike_out, 0);
    reset_l = 1'b1;

    chk("model_step1", next_id('h32D), 'h25B);
    chk("model_step2", next_id('h25B), 'h0B6);

    set_all(1);
    spike_in[TW*'h25B +: TW] = 2'b10;
    start_round(1, 0);
    observe(0, 0, 50, lv, ld, nv, hs, w0);
    chk("basic_word", w0, 12'hA5B);
    chk("basic_lat_valid", lv, 2);
    chk("basic_valid_cycles", nv, 1);
    chk("basic_lat_done", ld, 3);

    start_round(1, 0);
    observe(0, 0, 50, lv, ld, nv, hs, w0);
    chk("continue_word", w0, 12'h4B6);
    chk("continue_lat_valid", lv, 2);

    do_reset();
    start_round(1, 0);
    observe(6, 0, 50, lv, ld, nv, hs, w0);
    chk("stall_word", w0, 12'hA5B);
    chk("stall_valid_cycles", nv, 6);
    chk("stall_handshakes", hs, 1);
    chk("stall_lat_done", ld, 8);

    start_round(0, 0);
    observe(0, 0, 10, lv, ld, nv, hs, w0);
    chk("zero_lat_done", ld, 1);
    chk("zero_valid_cycles", nv, 0);

    set_all(0);
    start_round(3, 1);
    observe(0, 0, 1100, lv, ld, nv, hs, w0);
    chk("allzero_lat_done", ld, 1024);
    chk("allzero_valid_cycles", nv, 0);

    for (int r = 0; r < 70; r++) begin
      rand_spikes();
      start_round(15, 1'($urandom_range(0, 1)));
      observe(-1, 1, 3000, lv, ld, nv, hs, w0);
      chk("rand_handshakes", hs, 15);
    end

    do_reset();
    set_all(1);
    spike_in[TW*'h25B +: TW] = 2'b10;
    start_round(1, 0);
    spike_out_ready = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      en_network = 1'b0;
      if (spike_out_valid) break;
    end
    chk("emit_reached", spike_out_valid, 1);
    #2 reset_l = 1'b0;
    #1;
    chk("async_rst_valid", spike_out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", networkDone, 0);
    chk("async_rst_word", spike_out, 0);
    @(negedge clk);
    reset_l = 1'b1;
    spike_out_ready = 1'b1;
    start_round(1, 0);
    observe(0, 0, 50, lv, ld, nv, hs, w0);
    chk("post_rst_word", w0, 12'hA5B);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
